cookie_ctrl: RTL and testbench

//   Sequencer for the 16x16 cookie life grid: loads a 256-bit pattern, advances N generations, snapshots and streams it out.

---
 rtl/cookie_ctrl_if.sv | 24 ++
 rtl/cookie_ctrl.sv | 135 +++++++++++++
 tb/tb_cookie_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cookie_ctrl_if.sv
// Host-side command and bit-stream bundle for cookie_ctrl.
// Valid/ready: a beat transfers on a rising edge where valid and ready are both high; payload is only meaningful while valid is high.
interface cookie_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_count;
  logic       din_valid;
  logic       din_bit;
  logic       din_ready;
  logic       dout_valid;
  logic       dout_bit;
  logic       dout_ready;

  modport master (
    output cmd_valid, cmd_op, cmd_count, din_valid, din_bit, dout_ready,
    input  cmd_ready, din_ready, dout_valid, dout_bit
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, din_valid, din_bit, dout_ready,
    output cmd_ready, din_ready, dout_valid, dout_bit
  );
endinterface

// File: rtl/cookie_ctrl.sv
// Load / step / snapshot-and-dump sequencer driving one cookie life grid.
// Optional COOKIE_CTRL_AUTO_DUMP_EN: every STEP with a non-zero count ends with a snapshot and dump.
module cookie_ctrl #(
  parameter int CELLS   = 256,
  parameter int RUN_GAP = 1,
  parameter int GEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  cookie_ctrl_if.slave     host,
  output logic             busy,
  output logic [GEN_W-1:0] gen_total,
  output logic             cookie_en,
  output logic             cookie_run,
  output logic             cookie_display,
  output logic             cookie_in_bit,
  output logic             cookie_dshift_in,
  input  logic             cookie_out_bit,
  input  logic             cookie_dshift_out,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_GAP  = 3'd3,
    S_SNAP = 3'd4,
    S_DUMP = 3'd5
  } state_t;

  localparam int CNT_W = $clog2(CELLS) + 1;
  localparam int GAP_W = $clog2(RUN_GAP + 1) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CELLS - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((RUN_GAP > 0) ? RUN_GAP - 1 : 0);

  // Where a STEP goes once its last generation has been run.
`ifdef COOKIE_CTRL_AUTO_DUMP_EN
  localparam state_t STEP_DONE = S_SNAP;
`else
  localparam state_t STEP_DONE = S_IDLE;
`endif

  state_t           state;
  logic             alive;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       remaining;
  logic [GAP_W-1:0] gap_cnt;
  logic             cmd_fire;
  logic             load_fire;
  logic             dump_fire;

  // alive keeps cmd_ready low while reset is held and until the first edge after release.
  assign host.cmd_ready  = alive && (state == S_IDLE);
  assign host.din_ready  = (state == S_LOAD);
  assign host.dout_valid = (state == S_DUMP);
  assign host.dout_bit   = host.dout_valid & cookie_dshift_out;

  assign cmd_fire  = host.cmd_valid & host.cmd_ready;
  assign load_fire = host.din_ready & host.din_valid;
  assign dump_fire = host.dout_valid & host.dout_ready;

  // Dump feeds the state chain's own output back in so the grid survives readout.
  assign cookie_en        = load_fire | dump_fire;
  assign cookie_in_bit    = load_fire ? host.din_bit : (dump_fire & cookie_out_bit);
  assign cookie_run       = (state == S_RUN);
  assign cookie_display   = (state == S_SNAP);
  assign cookie_dshift_in = 1'b0;
  assign busy             = (state != S_IDLE);
  assign dbg_state        = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      alive     <= 1'b0;
      bit_cnt   <= '0;
      remaining <= '0;
      gap_cnt   <= '0;
      gen_total <= '0;
    end else begin
      alive <= 1'b1;
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            case (host.cmd_op)
              2'd0: begin
                state     <= S_LOAD;
                bit_cnt   <= '0;
                gen_total <= '0;
              end
              2'd1: begin
                if (host.cmd_count != 8'd0) begin
                  remaining <= host.cmd_count;
                  state     <= S_RUN;
                end
              end
              2'd2: state <= S_SNAP;
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          if (load_fire) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state <= S_IDLE;
          end
        end
        S_RUN: begin
          remaining <= remaining - 8'd1;
          gen_total <= gen_total + 1'b1;
          gap_cnt   <= '0;
          if (RUN_GAP > 0) state <= S_GAP;
          else if (remaining > 8'd1) state <= S_RUN;
          else state <= STEP_DONE;
        end
        S_GAP: begin
          if (gap_cnt == LAST_GAP) state <= (remaining != 8'd0) ? S_RUN : STEP_DONE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        S_SNAP: begin
          bit_cnt <= '0;
          state   <= S_DUMP;
        end
        S_DUMP: begin
          if (dump_fire) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cookie_ctrl.sv
// Directed bench for cookie_ctrl with a behavioural 16x16 life grid standing in for the cookie.
// Honours COOKIE_CTRL_AUTO_DUMP_EN when the design is built with it.
module tb_cookie_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] gen_total;
  logic        cookie_en, cookie_run, cookie_display, cookie_in_bit, cookie_dshift_in;
  logic        cookie_out_bit, cookie_dshift_out;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cookie_ctrl_if bus ();

  cookie_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .host              (bus.slave),
    .busy              (busy),
    .gen_total         (gen_total),
    .cookie_en         (cookie_en),
    .cookie_run        (cookie_run),
    .cookie_display    (cookie_display),
    .cookie_in_bit     (cookie_in_bit),
    .cookie_dshift_in  (cookie_dshift_in),
    .cookie_out_bit    (cookie_out_bit),
    .cookie_dshift_out (cookie_dshift_out),
    .dbg_state         (dbg_state)
  );

  // Cookie stand-in: state chain, display chain and a bounded-edge life rule.
  logic [255:0] grid = '0;
  logic [255:0] disp = '0;
  assign cookie_out_bit    = grid[255];
  assign cookie_dshift_out = disp[255];

  function automatic logic [255:0] life_next(input logic [255:0] g);
    logic [255:0] nx;
    int n;
    nx = '0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 16 && c + dc >= 0 && c + dc < 16)
              n += int'(g[(r + dr) * 16 + c + dc]);
        nx[r * 16 + c] = g[r * 16 + c] ? (n == 2 || n == 3) : (n == 3);
      end
    end
    return nx;
  endfunction

  always @(posedge clk) begin
    if (cookie_en) begin
      grid <= {grid[254:0], cookie_in_bit};
      disp <= {disp[254:0], cookie_dshift_in};
    end else if (cookie_run) begin
      grid <= life_next(grid);
    end else if (cookie_display) begin
      disp <= grid;
    end
  end

  // Free-running pulse monitors; tests look at differences against a snapshot.
  int cyc = 0;
  int en_cnt = 0;
  int run_cnt = 0;
  int disp_cnt = 0;
  int excl_viol = 0;
  int run_at[$];

  always @(posedge clk) begin
    cyc++;
    if (cookie_en) en_cnt++;
    if (cookie_run) begin
      run_cnt++;
      run_at.push_back(cyc);
    end
    if (cookie_display) disp_cnt++;
    if (int'(cookie_en) + int'(cookie_run) + int'(cookie_display) > 1) excl_viol++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] cnt);
    int guard;
    guard = 0;
    while (!bus.cmd_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.cmd_ready) check("cmd_ready_wait", 256'(bus.cmd_ready), 256'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_count = cnt;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd3;
    bus.cmd_count = 8'd0;
  endtask

  task automatic load(input logic [255:0] pat, input bit stall);
    send_cmd(2'd0, 8'd0);
    check("load_din_ready", 256'(bus.din_ready), 256'd1);
    for (int i = 0; i < 256; i++) begin
      if (stall && $urandom_range(0, 3) == 0) begin
        bus.din_valid = 1'b0;
        @(negedge clk);
      end
      bus.din_valid = 1'b1;
      bus.din_bit   = pat[255 - i];
      @(negedge clk);
    end
    bus.din_valid = 1'b0;
    bus.din_bit   = 1'b0;
  endtask

  task automatic collect_dump(output logic [255:0] got, input bit toggle);
    int k;
    int guard;
    logic rdy;
    k = 0;
    guard = 0;
    got = '0;
    while (k < 256 && guard < 3000) begin
      if (bus.dout_valid) begin
        rdy = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.dout_ready = rdy;
        if (rdy) begin
          got[255 - k] = bus.dout_bit;
          k++;
        end
      end else begin
        bus.dout_ready = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    bus.dout_ready = 1'b0;
    check("dump_len", 256'(k), 256'd256);
  endtask

  task automatic dump(output logic [255:0] got, input bit toggle);
    send_cmd(2'd2, 8'd0);
    collect_dump(got, toggle);
  endtask

  task automatic do_step(input logic [7:0] n, output int busy_cycles, output logic [255:0] auto_got);
    int guard;
    auto_got = '0;
    send_cmd(2'd1, n);
    busy_cycles = 0;
    guard = 0;
`ifdef COOKIE_CTRL_AUTO_DUMP_EN
    if (n != 8'd0) collect_dump(auto_got, 1'b0);
`endif
    while (busy && guard < 3000) begin
      busy_cycles++;
      @(negedge clk);
      guard++;
    end
    if (busy) check("step_timeout", 256'(busy), 256'd0);
  endtask

  logic [255:0] pat_a, blink_h, blink_v, got, got2, auto_got;
  int en_base, run_base, disp_base, busy_cycles, nrun;

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'd3;
    bus.cmd_count  = 8'd0;
    bus.din_valid  = 1'b0;
    bus.din_bit    = 1'b0;
    bus.dout_ready = 1'b0;

    pat_a   = {16{16'h0001}};
    blink_h = '0;
    blink_h[8'h77] = 1'b1;
    blink_h[8'h78] = 1'b1;
    blink_h[8'h79] = 1'b1;
    blink_v = '0;
    blink_v[8'h68] = 1'b1;
    blink_v[8'h78] = 1'b1;
    blink_v[8'h88] = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 256'(bus.cmd_ready), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_gen_total", 256'(gen_total), 256'd0);
    check("rst_pins", 256'({cookie_en, cookie_run, cookie_display, cookie_in_bit, cookie_dshift_in}), 256'd0);
    check("rst_streams", 256'({bus.din_ready, bus.dout_valid, bus.dout_bit}), 256'd0);
    check("rst_state", 256'(dbg_state), 256'd0);
    rst_n = 1'b1;
    check("release_cmd_ready_low", 256'(bus.cmd_ready), 256'd0);
    @(negedge clk);
    check("release_cmd_ready", 256'(bus.cmd_ready), 256'd1);

    // Load with stalls, then dump and confirm recirculation
    en_base = en_cnt;
    load(pat_a, 1'b1);
    check("load_en_pulses", 256'(en_cnt - en_base), 256'd256);
    check("load_grid", grid, pat_a);
    check("load_idle", 256'(busy), 256'd0);
    en_base = en_cnt;
    disp_base = disp_cnt;
    dump(got, 1'b0);
    check("dump_a_bits", got, pat_a);
    check("dump_a_en_pulses", 256'(en_cnt - en_base), 256'd256);
    check("dump_a_display", 256'(disp_cnt - disp_base), 256'd1);
    check("dump_a_grid_kept", grid, pat_a);

    // Blinker, one generation
    load(blink_h, 1'b0);
    check("blink_gen_total_cleared", 256'(gen_total), 256'd0);
    run_base = run_cnt;
    do_step(8'd1, busy_cycles, auto_got);
    check("step1_runs", 256'(run_cnt - run_base), 256'd1);
    check("step1_gen_total", 256'(gen_total), 256'd1);
`ifdef COOKIE_CTRL_AUTO_DUMP_EN
    check("step1_auto_dump", auto_got, blink_v);
`else
    check("step1_busy", 256'(busy_cycles), 256'd2);
    dump(got, 1'b0);
    check("step1_dump", got, blink_v);
`endif

    // Three generations, gap spacing
    run_base  = run_cnt;
    disp_base = disp_cnt;
    do_step(8'd3, busy_cycles, auto_got);
    nrun = run_at.size();
    check("step3_runs", 256'(run_cnt - run_base), 256'd3);
    check("step3_spacing_a", 256'(run_at[nrun - 2] - run_at[nrun - 3]), 256'd2);
    check("step3_spacing_b", 256'(run_at[nrun - 1] - run_at[nrun - 2]), 256'd2);
    check("step3_gen_total", 256'(gen_total), 256'd4);
`ifdef COOKIE_CTRL_AUTO_DUMP_EN
    check("step3_auto_display", 256'(disp_cnt - disp_base), 256'd1);
    check("step3_auto_dump", auto_got, blink_h);
`else
    check("step3_busy", 256'(busy_cycles), 256'd6);
    check("step3_no_display", 256'(disp_cnt - disp_base), 256'd0);
`endif

    // Two dumps with a stuttering sink
    dump(got, 1'b1);
    dump(got2, 1'b1);
    check("dump_twice_equal", got2, got);
    check("dump_twice_value", got, blink_h);
    check("dump_twice_grid", grid, blink_h);

    // STEP 0 and NOP do nothing
    run_base = run_cnt;
    en_base  = en_cnt;
    send_cmd(2'd1, 8'd0);
    check("step0_busy", 256'(busy), 256'd0);
    send_cmd(2'd3, 8'd0);
    check("nop_busy", 256'(busy), 256'd0);
    check("step0_nop_runs", 256'(run_cnt - run_base), 256'd0);
    check("step0_nop_en", 256'(en_cnt - en_base), 256'd0);
    check("step0_gen_total", 256'(gen_total), 256'd4);

    // Reset in the middle of a load
    en_base = en_cnt;
    send_cmd(2'd0, 8'd0);
    for (int i = 0; i < 100; i++) begin
      bus.din_valid = 1'b1;
      bus.din_bit   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_en", 256'(cookie_en), 256'd0);
    check("midrst_outputs", 256'({bus.cmd_ready, bus.din_ready, bus.dout_valid, busy, cookie_run, cookie_display, cookie_in_bit}), 256'd0);
    check("midrst_state", 256'(dbg_state), 256'd0);
    bus.din_valid = 1'b0;
    bus.din_bit   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_cmd_ready", 256'(bus.cmd_ready), 256'd1);
    check("midrst_gen_total", 256'(gen_total), 256'd0);
    check("midrst_partial_en", 256'(en_cnt - en_base), 256'd100);

    // Fresh load after the abandoned one still works
    load(blink_v, 1'b0);
    check("reload_grid", grid, blink_v);

    check("pins_exclusive", 256'(excl_viol), 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
